// File: rtl/raid0_stripe_splitter.sv
// raid0_stripe_splitter: takes one host block request, cuts it at stripe
// boundaries into per-device sub-requests, issues them one at a time, and
// counts completions so it can report a single done/done_err per request.
module raid0_stripe_splitter #(
  parameter int STRIPE_LOG2 = 3,
  parameter int DEV_LOG2    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_lba,
  input  logic [15:0]         req_cnt,
  input  logic                req_write,
  output logic                sub_valid,
  input  logic                sub_ready,
  output logic [DEV_LOG2-1:0] sub_dev,
  output logic [31:0]         sub_lba,
  output logic [15:0]         sub_cnt,
  output logic                sub_write,
  output logic                sub_last,
  input  logic                cpl_valid,
  input  logic                cpl_err,
  output logic                done,
  output logic                done_err,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT_CPL,
    DONE
  } state_t;

  // Stripe size in blocks; at most 2^15 so it always fits the 16-bit count.
  localparam logic [15:0] STRIPE_BLKS = 16'(32'd1 << STRIPE_LOG2);
  localparam logic [15:0] OFS_MASK    = STRIPE_BLKS - 16'd1;

  // Smaller of two unsigned block counts.
  function automatic logic [15:0] min_u16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t              state_q, state_d;
  logic [31:0]         lba_q, lba_d;
  logic [15:0]         rem_q, rem_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [16:0]         outst_q, outst_d;
  logic [DEV_LOG2-1:0] sub_dev_q, sub_dev_d;
  logic [31:0]         sub_lba_q, sub_lba_d;
  logic [15:0]         sub_cnt_q, sub_cnt_d;
  logic                sub_write_q, sub_write_d;
  logic                sub_last_q, sub_last_d;

  logic [31:0] stripe_idx;
  logic [31:0] dev_lba;
  logic [15:0] ofs;
  logic [15:0] room;
  logic [15:0] chunk;
  logic        sub_hs;
  logic        cpl_acc;

  // Address split of the current LBA: stripe index, offset, device-local LBA and chunk length.
  always_comb begin
    stripe_idx = lba_q >> STRIPE_LOG2;
    ofs        = lba_q[15:0] & OFS_MASK;
    room       = STRIPE_BLKS - ofs;
    chunk      = min_u16(rem_q, room);
    dev_lba    = ((stripe_idx >> DEV_LOG2) << STRIPE_LOG2) | {16'd0, ofs};
  end

  // Next-state, sub-request register loads and outstanding-completion bookkeeping.
  always_comb begin
    state_d     = state_q;
    lba_d       = lba_q;
    rem_d       = rem_q;
    write_d     = write_q;
    err_d       = err_q;
    outst_d     = outst_q;
    sub_dev_d   = sub_dev_q;
    sub_lba_d   = sub_lba_q;
    sub_cnt_d   = sub_cnt_q;
    sub_write_d = sub_write_q;
    sub_last_d  = sub_last_q;

    sub_hs  = (state_q == ISSUE) && sub_ready;
    // A completion with nothing outstanding is stray (e.g. after an abort) and is dropped.
    cpl_acc = cpl_valid && (outst_q != 17'd0);

    if (cpl_acc) begin
      err_d = err_q | cpl_err;
    end

    unique case ({sub_hs, cpl_acc})
      2'b10:   outst_d = outst_q + 17'd1;
      2'b01:   outst_d = outst_q - 17'd1;
      default: outst_d = outst_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          lba_d   = req_lba;
          rem_d   = req_cnt;
          write_d = req_write;
          err_d   = 1'b0;
          state_d = (req_cnt == 16'd0) ? DONE : CALC;
        end
      end
      CALC: begin
        sub_dev_d   = stripe_idx[DEV_LOG2-1:0];
        sub_lba_d   = dev_lba;
        sub_cnt_d   = chunk;
        sub_write_d = write_q;
        sub_last_d  = (chunk == rem_q);
        state_d     = ISSUE;
      end
      ISSUE: begin
        if (sub_ready) begin
          // LBA wraps modulo 2^32 by design.
          lba_d   = lba_q + {16'd0, sub_cnt_q};
          rem_d   = rem_q - sub_cnt_q;
          state_d = sub_last_q ? WAIT_CPL : CALC;
        end
      end
      WAIT_CPL: begin
        if (outst_q == 17'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to an idle, zeroed splitter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lba_q       <= 32'd0;
      rem_q       <= 16'd0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      outst_q     <= 17'd0;
      sub_dev_q   <= '0;
      sub_lba_q   <= 32'd0;
      sub_cnt_q   <= 16'd0;
      sub_write_q <= 1'b0;
      sub_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      rem_q       <= rem_d;
      write_q     <= write_d;
      err_q       <= err_d;
      outst_q     <= outst_d;
      sub_dev_q   <= sub_dev_d;
      sub_lba_q   <= sub_lba_d;
      sub_cnt_q   <= sub_cnt_d;
      sub_write_q <= sub_write_d;
      sub_last_q  <= sub_last_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign sub_valid = (state_q == ISSUE);
  assign sub_dev   = sub_dev_q;
  assign sub_lba   = sub_lba_q;
  assign sub_cnt   = sub_cnt_q;
  assign sub_write = sub_write_q;
  assign sub_last  = sub_last_q;
  assign done      = (state_q == DONE);
  assign done_err  = (state_q == DONE) && err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_raid0_stripe_splitter.sv
// Bench for raid0_stripe_splitter: driver issues host requests and completions,
// a reference model fills the expected queues, a negedge monitor checks outputs.
module tb_raid0_stripe_splitter;

  localparam int STRIPE_LOG2 = 3;
  localparam int DEV_LOG2    = 1;
  localparam longint unsigned STRIPE = 64'd1 << STRIPE_LOG2;
  localparam longint unsigned NDEV   = 64'd1 << DEV_LOG2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [31:0]         req_lba = 32'd0;
  logic [15:0]         req_cnt = 16'd0;
  logic                req_write = 1'b0;
  logic                sub_valid;
  logic                sub_ready = 1'b0;
  logic [DEV_LOG2-1:0] sub_dev;
  logic [31:0]         sub_lba;
  logic [15:0]         sub_cnt;
  logic                sub_write;
  logic                sub_last;
  logic                cpl_valid = 1'b0;
  logic                cpl_err = 1'b0;
  logic                done;
  logic                done_err;
  logic                busy;

  raid0_stripe_splitter #(.STRIPE_LOG2(STRIPE_LOG2), .DEV_LOG2(DEV_LOG2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_lba(req_lba),
    .req_cnt(req_cnt), .req_write(req_write),
    .sub_valid(sub_valid), .sub_ready(sub_ready), .sub_dev(sub_dev),
    .sub_lba(sub_lba), .sub_cnt(sub_cnt), .sub_write(sub_write), .sub_last(sub_last),
    .cpl_valid(cpl_valid), .cpl_err(cpl_err),
    .done(done), .done_err(done_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic   err;
    longint due;
  } done_t;

  logic [63:0] subq[$];
  longint      svq[$];
  done_t       dq[$];

  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc      = 0;
  logic   rst_d    = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_d <= rst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: split a request with plain stripe arithmetic.
  task automatic push_model(input logic [31:0] lba, input int cnt, input logic wr);
    longint unsigned a, s, o, chunk, dl;
    int rem;
    logic [DEV_LOG2-1:0] d;
    logic [31:0] l32;
    logic [15:0] c16;
    logic        last;
    a = lba;
    rem = cnt;
    while (rem > 0) begin
      s     = a / STRIPE;
      o     = a % STRIPE;
      dl    = (s / NDEV) * STRIPE + o;
      chunk = (longint'(rem) < (STRIPE - o)) ? longint'(rem) : (STRIPE - o);
      d     = DEV_LOG2'(s % NDEV);
      l32   = 32'(dl);
      c16   = 16'(chunk);
      last  = (chunk == longint'(rem));
      subq.push_back(64'({d, l32, c16, wr, last}));
      a   = (a + chunk) % (64'd1 << 32);
      rem = rem - int'(chunk);
    end
  endtask

  logic [63:0] cur_sub;
  assign cur_sub = 64'({sub_dev, sub_lba, sub_cnt, sub_write, sub_last});

  logic [63:0] saved_sub;
  bit          prev_stall = 1'b0;
  bit          prev_done  = 1'b0;

  // Monitor: compare outputs against the expected queues, mid-cycle.
  always @(negedge clk) begin
    logic [63:0] e;
    done_t       de;
    if (rst_d) begin
      check("reset req_ready", 64'(req_ready), 64'(!rst));
      check("reset outputs", 64'({sub_valid, busy, done, done_err, sub_write, sub_last,
                                  sub_dev, sub_cnt, sub_lba}), 64'd0);
      subq.delete();
      svq.delete();
      dq.delete();
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (svq.size() > 0) begin
        if (svq[0] == cyc + 1) check("sub_valid before latency", 64'(sub_valid), 64'd0);
        else if (svq[0] == cyc) begin
          check("first sub latency", 64'(sub_valid), 64'd1);
          void'(svq.pop_front());
        end
      end
      if (prev_stall) check("sub held while stalled", {sub_valid, cur_sub[62:0]}, {1'b1, saved_sub[62:0]});
      if (sub_valid && subq.size() == 0) check("unexpected sub_valid", 64'(sub_valid), 64'd0);
      else if (sub_valid && sub_ready) begin
        e = subq.pop_front();
        check("sub fields {dev,lba,cnt,wr,last}", cur_sub, e);
      end
      prev_stall = sub_valid && !sub_ready;
      saved_sub  = cur_sub;
      if (prev_done) check("idle after done {ready,busy,done}", 64'({req_ready, busy, done}), 64'b100);
      if (done) begin
        if (dq.size() == 0) check("unexpected done", 64'(done), 64'd0);
        else begin
          de = dq.pop_front();
          check("done_err", 64'(done_err), 64'(de.err));
          check("done cycle", 64'(cyc), 64'(de.due));
          check("busy during done", 64'(busy), 64'd1);
        end
      end else if (dq.size() > 0 && cyc > dq[0].due) begin
        check("done missing", 64'(cyc), 64'(dq[0].due));
        void'(dq.pop_front());
      end
      prev_done = done;
    end
  end

  // Issue one host request and service its sub-requests/completions.
  task automatic run_req(input logic [31:0] lba, input int cnt, input logic wr,
                         input int rdy_pct, input int cpl_pct, input int err_pct,
                         input int err_idx, input bit defer, input int stall2, input bit abort2);
    int g, pend, issued, ncpl, stalls;
    bit last_seen, err, rdy, hs, dc, de, fin;
    g = 0;
    while (!req_ready && g < 100) begin tick(); g++; end
    check("req_ready before request", 64'(req_ready), 64'd1);
    push_model(lba, cnt, wr);
    req_valid = 1'b1; req_lba = lba; req_cnt = 16'(cnt); req_write = wr;
    if (cnt == 0) dq.push_back('{1'b0, cyc + 1});
    else svq.push_back(cyc + 2);
    tick();
    req_valid = 1'b0;
    pend = 0; issued = 0; ncpl = 0; stalls = 0;
    last_seen = 0; err = 0; fin = (cnt == 0); g = 0;
    while (!fin && g < 3000) begin
      if (abort2 && issued == 1 && sub_valid) begin
        rst = 1'b1; sub_ready = 1'b0; cpl_valid = 1'b0; cpl_err = 1'b0;
        tick();
        rst = 1'b0;
        return;
      end
      rdy = int'($urandom % 100) < rdy_pct;
      if (stall2 > 0 && issued == 1 && sub_valid && stalls < stall2) begin
        rdy = 1'b0;
        stalls++;
      end
      hs = sub_valid && rdy;
      dc = (pend > 0) && (!defer || last_seen) && (int'($urandom % 100) < cpl_pct);
      de = dc && ((ncpl == err_idx) || (int'($urandom % 100) < err_pct));
      sub_ready = rdy; cpl_valid = dc; cpl_err = de;
      if (dc) begin pend--; ncpl++; err = err | de; end
      if (hs) begin pend++; issued++; if (sub_last) last_seen = 1'b1; end
      if (dc && last_seen && pend == 0) begin
        dq.push_back('{err, cyc + 2});
        fin = 1'b1;
      end
      tick();
      g++;
    end
    check("request progress", 64'(fin), 64'd1);
    sub_ready = 1'b0; cpl_valid = 1'b0; cpl_err = 1'b0;
    g = 0;
    while (busy && g < 20) begin tick(); g++; end
    check("return to idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] rl;
    int          rc;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    // single full stripe
    run_req(32'd0, 8, 1'b0, 100, 100, 0, -1, 1'b0, 0, 1'b0);
    // unaligned, four subs, completions only after the last issue
    run_req(32'd5, 20, 1'b1, 100, 100, 0, -1, 1'b1, 0, 1'b0);
    // LBA wrap and zero count
    run_req(32'hFFFF_FFFE, 4, 1'b0, 100, 60, 0, -1, 1'b0, 0, 1'b0);
    run_req(32'd77, 0, 1'b1, 100, 100, 0, -1, 1'b0, 0, 1'b0);
    // downstream stall on second sub, completions overlapping issues
    run_req(32'd5, 20, 1'b0, 100, 70, 0, -1, 1'b0, 10, 1'b0);
    // error on second completion, then a clean request
    run_req(32'd0, 32, 1'b1, 100, 50, 0, 1, 1'b0, 0, 1'b0);
    run_req(32'd0, 32, 1'b1, 100, 50, 0, -1, 1'b0, 0, 1'b0);
    // reset during second sub, stray completions, then a fresh request
    run_req(32'd0, 20, 1'b0, 100, 0, 0, -1, 1'b0, 0, 1'b1);
    cpl_valid = 1'b1; cpl_err = 1'b1;
    repeat (3) tick();
    cpl_valid = 1'b0; cpl_err = 1'b0;
    tick();
    run_req(32'd0, 8, 1'b0, 100, 100, 0, -1, 1'b0, 0, 1'b0);
    // randomized requests
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 3)
        0: rl = $urandom;
        1: rl = 32'hFFFF_FFFF - ($urandom % 40);
        default: rl = $urandom % 64;
      endcase
      rc = (($urandom % 10) == 0) ? 0 : int'($urandom % 50) + 1;
      run_req(rl, rc, 1'($urandom), 70, 50, 10, -1, 1'b0, 0, 1'b0);
    end
    repeat (5) tick();
    check("expected queues drained", 64'(subq.size() + svq.size() + dq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
